// File: rtl/lamp_sweep_sched.sv
// Lamp bar sweep scheduler: round-robin arbitration among requesters, each
// granted command ramps a thermometer lamp bar one lamp per STEP_DIV cycles
// towards its target, holds HOLD_CYC cycles after done, then releases the bar.
module lamp_sweep_sched #(
   parameter int unsigned MAX_LP   = 16,
   parameter int unsigned NREQ     = 3,
   parameter int unsigned STEP_DIV = 4,
   parameter int unsigned HOLD_CYC = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req,
   input  logic [5*NREQ-1:0] tgt,
   input  logic              abort,
   output logic [NREQ-1:0]   ack,
   output logic [NREQ-1:0]   grant,
   output logic [NREQ-1:0]   done,
   output logic              busy,
   output logic [MAX_LP-1:0] lamp
);

   localparam int unsigned LW = $clog2(MAX_LP + 1);
   localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam int unsigned HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

   typedef enum logic [1:0] {StIdle, StRampUp, StRampDn, StHold} state_e;

   state_e            state_q, state_d;
   logic [LW-1:0]     level_q, level_d;
   logic [LW-1:0]     target_q, target_d;
   logic [PW-1:0]     presc_q, presc_d;
   logic [HW-1:0]     hold_q, hold_d;
   logic [IW-1:0]     last_q, last_d;
   logic [IW-1:0]     owner_q, owner_d;
   logic [NREQ-1:0]   ack_q, ack_d;
   logic [NREQ-1:0]   grant_q, grant_d;
   logic [NREQ-1:0]   done_q, done_d;
   // Direct-to-HOLD entry defers done by one cycle so it follows the ack.
   logic              done_pend_q, done_pend_d;
   // Blocks arbitration in the first IDLE cycle after a release.
   logic              skip_q, skip_d;

   logic              win_found;
   logic [IW-1:0]     win_idx;
   logic [IW-1:0]     cand;
   logic [4:0]        raw_tgt;
   logic [LW-1:0]     t_clamp;
   logic [LW-1:0]     step_lvl;

   // Round-robin search starting after the last granted requester.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         cand = IW'((32'(last_q) + k) % NREQ);
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   // Winner's target, clamped to the bar length.
   always_comb begin
      raw_tgt = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (win_idx == IW'(i)) raw_tgt = tgt[5*i +: 5];
      end
      if (32'(raw_tgt) > MAX_LP) t_clamp = LW'(MAX_LP);
      else                       t_clamp = LW'(raw_tgt);
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d     = state_q;
      level_d     = level_q;
      target_d    = target_q;
      presc_d     = presc_q;
      hold_d      = hold_q;
      last_d      = last_q;
      owner_d     = owner_q;
      ack_d       = '0;
      grant_d     = grant_q;
      done_d      = '0;
      done_pend_d = done_pend_q;
      skip_d      = skip_q;
      step_lvl    = (state_q == StRampUp) ? level_q + LW'(1) : level_q - LW'(1);

      unique case (state_q)
         StIdle: begin
            if (skip_q) begin
               skip_d = 1'b0;
            end else if (win_found) begin
               owner_d  = win_idx;
               grant_d  = NREQ'(1) << win_idx;
               ack_d    = NREQ'(1) << win_idx;
               target_d = t_clamp;
               presc_d  = '0;
               hold_d   = '0;
               if (t_clamp > level_q) begin
                  state_d = StRampUp;
               end else if (t_clamp < level_q) begin
                  state_d = StRampDn;
               end else begin
                  state_d     = StHold;
                  done_pend_d = 1'b1;
               end
            end
         end
         StRampUp, StRampDn: begin
            if (abort) begin
               state_d = StIdle;
               grant_d = '0;
               last_d  = owner_q;
               skip_d  = 1'b1;
            end else if (presc_q == PW'(STEP_DIV - 1)) begin
               presc_d = '0;
               level_d = step_lvl;
               if (step_lvl == target_q) begin
                  state_d = StHold;
                  done_d  = grant_q;
                  hold_d  = '0;
               end
            end else begin
               presc_d = presc_q + PW'(1);
            end
         end
         StHold: begin
            if (done_pend_q) begin
               done_d      = grant_q;
               done_pend_d = 1'b0;
            end else if (hold_q == HW'(HOLD_CYC - 1)) begin
               state_d = StIdle;
               grant_d = '0;
               last_d  = owner_q;
               skip_d  = 1'b1;
            end else begin
               hold_d = hold_q + HW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         level_q     <= '0;
         target_q    <= '0;
         presc_q     <= '0;
         hold_q      <= '0;
         last_q      <= IW'(NREQ - 1);
         owner_q     <= '0;
         ack_q       <= '0;
         grant_q     <= '0;
         done_q      <= '0;
         done_pend_q <= 1'b0;
         skip_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         level_q     <= level_d;
         target_q    <= target_d;
         presc_q     <= presc_d;
         hold_q      <= hold_d;
         last_q      <= last_d;
         owner_q     <= owner_d;
         ack_q       <= ack_d;
         grant_q     <= grant_d;
         done_q      <= done_d;
         done_pend_q <= done_pend_d;
         skip_q      <= skip_d;
      end
   end

   // Outputs are direct register values or decodes of registers only.
   always_comb begin
      ack   = ack_q;
      grant = grant_q;
      done  = done_q;
      busy  = (state_q != StIdle);
      lamp  = '0;
      for (int unsigned k = 0; k < MAX_LP; k++) begin
         lamp[k] = (k < 32'(level_q));
      end
   end

endmodule
